// File: rtl/gpio_chain_sequencer.sv
// gpio_chain_sequencer: fetches one configuration word per GPIO block and shifts
// the whole chain out MSB first, then strobes the load line for two cycles.
`default_nettype none

module gpio_chain_sequencer #(
  parameter int NUM_GPIO      = 19,
  parameter int PAD_CTRL_BITS = 13
) (
  input  logic                     serial_clock,
  input  logic                     resetn,
  input  logic                     start,
  output logic [4:0]               cfg_addr,
  input  logic [PAD_CTRL_BITS-1:0] cfg_data,
  output logic                     chain_clock,
  output logic                     chain_data,
  output logic                     chain_load,
  output logic                     busy,
  output logic                     done
);

  localparam int BW = (PAD_CTRL_BITS > 1) ? $clog2(PAD_CTRL_BITS) : 1;
  localparam logic [BW-1:0] BIT_TOP  = BW'(PAD_CTRL_BITS - 1);
  localparam logic [4:0]    ADDR_TOP = 5'(NUM_GPIO - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    SETTLE   = 3'd4,
    LOAD     = 3'd5
  } state_t;

  state_t                   state, state_next;
  logic [PAD_CTRL_BITS-1:0] word, word_next;
  logic [BW-1:0]            bit_idx, bit_next;
  logic                     load_phase, load_next;
  logic [4:0]               addr_next;
  logic                     clk_next, data_next, ld_next, busy_next, done_next;

  // All outputs are registered: the next-cycle values are decoded here and
  // captured alongside the state, so every output is glitch-free.
  always_comb begin
    state_next = state;
    word_next  = word;
    bit_next   = bit_idx;
    load_next  = load_phase;
    addr_next  = cfg_addr;
    clk_next   = 1'b0;
    data_next  = 1'b0;
    ld_next    = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          addr_next  = ADDR_TOP;
        end
      end
      FETCH: begin
        state_next = SHIFT_LO;
        word_next  = cfg_data;
        bit_next   = BIT_TOP;
        data_next  = cfg_data[BIT_TOP];
      end
      SHIFT_LO: begin
        state_next = SHIFT_HI;
        clk_next   = 1'b1;
        data_next  = chain_data;
      end
      SHIFT_HI: begin
        if (bit_idx != '0) begin
          state_next = SHIFT_LO;
          bit_next   = bit_idx - 1'b1;
          data_next  = word[bit_next];
        end else if (cfg_addr != 5'd0) begin
          state_next = FETCH;
          addr_next  = cfg_addr - 5'd1;
        end else begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        state_next = LOAD;
        ld_next    = 1'b1;
        load_next  = 1'b0;
      end
      LOAD: begin
        if (!load_phase) begin
          load_next = 1'b1;
          ld_next   = 1'b1;
        end else begin
          state_next = IDLE;
          load_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      word        <= '0;
      bit_idx     <= '0;
      load_phase  <= 1'b0;
      cfg_addr    <= 5'd0;
      chain_clock <= 1'b0;
      chain_data  <= 1'b0;
      chain_load  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      word        <= word_next;
      bit_idx     <= bit_next;
      load_phase  <= load_next;
      cfg_addr    <= addr_next;
      chain_clock <= clk_next;
      chain_data  <= data_next;
      chain_load  <= ld_next;
      busy        <= busy_next;
      done        <= done_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpio_chain_sequencer.sv
// Self-checking bench for gpio_chain_sequencer (NUM_GPIO=2, PAD_CTRL_BITS=13).
`default_nettype none

module tb_gpio_chain_sequencer;

  localparam int NG = 2;
  localparam int PB = 13;
  localparam int SEQ_LEN = NG * (2 * PB + 1) + 3;

  logic          serial_clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    cfg_addr;
  logic [PB-1:0] cfg_data;
  logic          chain_clock, chain_data, chain_load, busy, done;

  logic [PB-1:0] cfg_mem [NG];

  gpio_chain_sequencer #(.NUM_GPIO(NG), .PAD_CTRL_BITS(PB)) dut (
    .serial_clock(serial_clock),
    .resetn      (resetn),
    .start       (start),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .chain_clock (chain_clock),
    .chain_data  (chain_data),
    .chain_load  (chain_load),
    .busy        (busy),
    .done        (done)
  );

  assign cfg_data = (cfg_addr < 5'(NG)) ? cfg_mem[cfg_addr[0]] : '0;

  always #5 serial_clock = ~serial_clock;

  typedef struct packed {
    logic       bitv;
    logic [4:0] addr;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  int rise_cnt = 0, load_cyc = 0, done_cnt = 0, busy_run = 0, last_busy_len = 0;
  int toggle_viol = 0, done_viol = 0, gap0_cnt = 0, rise_after_load = 0;
  logic prev_clk = 0, prev_data = 0, prev_busy = 0, prev_done = 0, load_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge serial_clock) begin
    if (chain_clock && !prev_clk) begin
      if (sb.size() == 0) begin
        check("unexpected_rise", 32'(rise_cnt), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("chain_bit", 32'(chain_data), 32'(e.bitv));
        check("rise_addr", 32'(cfg_addr), 32'(e.addr));
      end
      if (chain_data !== prev_data) toggle_viol++;
      if (load_seen) rise_after_load++;
      rise_cnt++;
    end
    if (chain_load) begin
      load_cyc++;
      load_seen = 1'b1;
    end
    if (busy) busy_run++;
    else if (prev_busy) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
    if (done) begin
      done_cnt++;
      load_seen = 1'b0;
      if (!(prev_busy && !busy)) done_viol++;
    end
    if (prev_done && busy) gap0_cnt++;
    prev_clk  = chain_clock;
    prev_data = chain_data;
    prev_busy = busy;
    prev_done = done;
  end

  task automatic push_seq(input logic [PB-1:0] w1, input logic [PB-1:0] w0);
    for (int b = PB - 1; b >= 0; b--) sb.push_back({w1[b], 5'd1});
    for (int b = PB - 1; b >= 0; b--) sb.push_back({w0[b], 5'd0});
  endtask

  task automatic pulse_start();
    @(posedge serial_clock); #1 start = 1'b1;
    @(posedge serial_clock); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int c = 0;
    while (done_cnt < target && c < budget) begin
      @(posedge serial_clock);
      c++;
    end
    @(negedge serial_clock); #1;
    check("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_rises(input int target, input int budget);
    int c = 0;
    while (rise_cnt < target && c < budget) begin
      @(negedge serial_clock); #1;
      c++;
    end
    check("rise_timeout", 32'(rise_cnt >= target), 32'd1);
  endtask

  int r0, d0, l0;

  initial begin
    // Reset state
    repeat (3) @(posedge serial_clock);
    #1;
    check("rst_outputs", {26'd0, cfg_addr, chain_clock, chain_data, chain_load, busy, done}, 32'd0);
    resetn = 1'b1;
    repeat (2) @(posedge serial_clock);
    #1 check("idle_busy", 32'(busy), 32'd0);

    // Basic run; word 1 is overwritten after its fetch and must not leak in
    cfg_mem[1] = 13'h1803; cfg_mem[0] = 13'h0403;
    push_seq(13'h1803, 13'h0403);
    r0 = rise_cnt; d0 = done_cnt; l0 = load_cyc;
    pulse_start();
    wait_rises(r0 + 3, 200);
    cfg_mem[1] = 13'h0AAA;
    wait_done(d0 + 1, 200);
    check("basic_rises", 32'(rise_cnt - r0), 32'd26);
    check("basic_load", 32'(load_cyc - l0), 32'd2);
    check("basic_busy", 32'(last_busy_len), 32'(SEQ_LEN));
    check("basic_sb_empty", 32'(sb.size()), 32'd0);
    repeat (4) @(posedge serial_clock);
    #1;
    check("basic_one_done", 32'(done_cnt - d0), 32'd1);
    check("idle_outputs", {27'd0, chain_clock, chain_data, chain_load, busy, done}, 32'd0);
    check("idle_addr_hold", 32'(cfg_addr), 32'd0);

    // Start during busy is ignored
    cfg_mem[1] = 13'h1803;
    push_seq(13'h1803, 13'h0403);
    r0 = rise_cnt; d0 = done_cnt;
    pulse_start();
    while (busy_run < 10) begin @(negedge serial_clock); #1; end
    pulse_start();
    wait_done(d0 + 1, 200);
    repeat (70) @(posedge serial_clock);
    #1;
    check("ign_done", 32'(done_cnt - d0), 32'd1);
    check("ign_rises", 32'(rise_cnt - r0), 32'd26);
    check("ign_busy", 32'(busy), 32'd0);

    // Edge pattern: all ones then all zeros
    cfg_mem[1] = 13'h1FFF; cfg_mem[0] = 13'h0000;
    push_seq(13'h1FFF, 13'h0000);
    d0 = done_cnt;
    pulse_start();
    wait_done(d0 + 1, 200);
    check("edge_sb_empty", 32'(sb.size()), 32'd0);
    check("edge_busy", 32'(last_busy_len), 32'(SEQ_LEN));

    // Start held: back-to-back sequences
    cfg_mem[1] = 13'h1803; cfg_mem[0] = 13'h0403;
    push_seq(13'h1803, 13'h0403);
    push_seq(13'h1803, 13'h0403);
    r0 = rise_cnt; d0 = done_cnt; l0 = gap0_cnt;
    @(posedge serial_clock); #1 start = 1'b1;
    wait_done(d0 + 1, 200);
    check("b2b_len1", 32'(last_busy_len), 32'(SEQ_LEN));
    repeat (5) @(posedge serial_clock);
    #1 start = 1'b0;
    wait_done(d0 + 2, 200);
    check("b2b_len2", 32'(last_busy_len), 32'(SEQ_LEN));
    check("b2b_gap0", 32'(gap0_cnt - l0), 32'd1);
    check("b2b_rises", 32'(rise_cnt - r0), 32'd52);
    repeat (5) @(posedge serial_clock);
    #1 check("b2b_stop", 32'(busy), 32'd0);

    // Reset during the 7th SHIFT_HI aborts the sequence
    push_seq(13'h1803, 13'h0403);
    r0 = rise_cnt; d0 = done_cnt; l0 = load_cyc;
    pulse_start();
    wait_rises(r0 + 7, 200);
    resetn = 1'b0;
    #1;
    check("abort_outputs", {26'd0, cfg_addr, chain_clock, chain_data, chain_load, busy, done}, 32'd0);
    sb.delete();
    @(posedge serial_clock); #1 resetn = 1'b1;
    repeat (80) @(posedge serial_clock);
    #1;
    check("abort_no_load", 32'(load_cyc - l0), 32'd0);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);
    push_seq(13'h1803, 13'h0403);
    pulse_start();
    wait_done(d0 + 1, 200);
    check("rerun_busy", 32'(last_busy_len), 32'(SEQ_LEN));
    check("rerun_sb_empty", 32'(sb.size()), 32'd0);

    // Global invariants
    check("data_stable_when_high", 32'(toggle_viol), 32'd0);
    check("done_with_busy_fall", 32'(done_viol), 32'd0);
    check("rise_after_load", 32'(rise_after_load), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
